// File: rtl/stack_host_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : stack_host_ctrl_if
// Description : Host command/response and stack-device bus signals for
//               stack_host_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface stack_host_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_data_out;
  logic       stk_data_oe;
  logic [7:0] stk_data_in;
  logic       stk_done;
  logic       stk_empty;
  logic       stk_full;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  stk_data_in, stk_done, stk_empty, stk_full,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output stk_push, stk_pop, stk_data_out, stk_data_oe
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    output stk_data_in, stk_done, stk_empty, stk_full,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  stk_push, stk_pop, stk_data_out, stk_data_oe
  );
endinterface
`default_nettype wire

// File: rtl/stack_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stack_host_ctrl
// Description : Host-to-stack-device command sequencer (push/pop handshake).
//               Optional macro STACK_HOST_TIMEOUT_EN adds a device timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_host_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  stack_host_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  localparam logic [1:0] c_ERR_OK        = 2'b00;
  localparam logic [1:0] c_ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] c_ERR_UNDERFLOW = 2'b10;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_done_s1, r_done_s2;
  logic       r_empty_s1, r_empty_s2;
  logic       r_full_s1, r_full_s2;
  logic       r_op;
  logic [7:0] r_data;
  logic [7:0] r_rsp_data;
  logic [1:0] r_rsp_err;
  logic       w_load_cmd;
  logic       w_rsp_load;
  logic [7:0] w_rsp_data_nxt;
  logic [1:0] w_rsp_err_nxt;
  logic       w_drive_bus;

`ifdef STACK_HOST_TIMEOUT_EN
  localparam logic [1:0] c_ERR_TIMEOUT = 2'b11;
  localparam logic [7:0] c_TO_LIMIT    = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_to_cnt;
  logic       w_to_hit;

  // Counter holds k after the k-th edge spent in REQ/WAIT_DONE, so the abort
  // lands exactly TIMEOUT_CYCLES edges after REQ entry.
  assign w_to_hit = (r_to_cnt >= c_TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= 8'd0;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_REQ) begin
      r_to_cnt <= 8'd0;
    end else if ((r_state == ST_REQ || r_state == ST_WAIT_DONE) && r_to_cnt != 8'hFF) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_s1  <= 1'b0;
      r_done_s2  <= 1'b0;
      r_empty_s1 <= 1'b0;
      r_empty_s2 <= 1'b0;
      r_full_s1  <= 1'b0;
      r_full_s2  <= 1'b0;
    end else begin
      r_done_s1  <= bus.stk_done;
      r_done_s2  <= r_done_s1;
      r_empty_s1 <= bus.stk_empty;
      r_empty_s2 <= r_empty_s1;
      r_full_s1  <= bus.stk_full;
      r_full_s2  <= r_full_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= 1'b0;
      r_data     <= 8'd0;
      r_rsp_data <= 8'd0;
      r_rsp_err  <= c_ERR_OK;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_cmd) begin
        r_op   <= bus.cmd_op;
        r_data <= bus.cmd_data;
      end
      if (w_rsp_load) begin
        r_rsp_data <= w_rsp_data_nxt;
        r_rsp_err  <= w_rsp_err_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_load_cmd     = 1'b0;
    w_rsp_load     = 1'b0;
    w_rsp_data_nxt = 8'd0;
    w_rsp_err_nxt  = c_ERR_OK;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_load_cmd = 1'b1;
          if (bus.cmd_op && r_full_s2) begin
            w_state_nxt   = ST_RESP;
            w_rsp_load    = 1'b1;
            w_rsp_err_nxt = c_ERR_OVERFLOW;
          end else if (!bus.cmd_op && r_empty_s2) begin
            w_state_nxt   = ST_RESP;
            w_rsp_load    = 1'b1;
            w_rsp_err_nxt = c_ERR_UNDERFLOW;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
`ifdef STACK_HOST_TIMEOUT_EN
        if (w_to_hit) begin
          w_state_nxt   = ST_RESP;
          w_rsp_load    = 1'b1;
          w_rsp_err_nxt = c_ERR_TIMEOUT;
        end else
`endif
        if (!r_done_s2) begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A completion seen on the same edge as the timeout still wins.
        if (r_done_s2) begin
          w_state_nxt    = ST_RESP;
          w_rsp_load     = 1'b1;
          w_rsp_data_nxt = r_op ? 8'd0 : bus.stk_data_in;
        end
`ifdef STACK_HOST_TIMEOUT_EN
        else if (w_to_hit) begin
          w_state_nxt   = ST_RESP;
          w_rsp_load    = 1'b1;
          w_rsp_err_nxt = c_ERR_TIMEOUT;
        end
`endif
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_drive_bus      = r_op && (r_state == ST_REQ || r_state == ST_WAIT_DONE);
  assign bus.cmd_ready    = (r_state == ST_IDLE);
  assign bus.rsp_valid    = (r_state == ST_RESP);
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.stk_push     = (r_state == ST_REQ) && r_op;
  assign bus.stk_pop      = (r_state == ST_REQ) && !r_op;
  assign bus.stk_data_oe  = w_drive_bus;
  assign bus.stk_data_out = w_drive_bus ? r_data : 8'd0;

endmodule
`default_nettype wire
